// File: rtl/tilt_pkg.sv
// tilt_pkg: shared types and helpers for the tilt letter decoder.
//   tilt_state_e : decoder FSM states
//   AXIS_*       : source-axis identifiers carried on axis_out
//   cnt_width    : width of the hold counter (counts 0..hold)
//   bin_width    : width of a bin index for n bins
package tilt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        EMIT,
        RELEASE
    } tilt_state_e;

    localparam logic [1:0] AXIS_X = 2'd0;
    localparam logic [1:0] AXIS_Y = 2'd1;
    localparam logic [1:0] AXIS_Z = 2'd2;

    function automatic int cnt_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

    function automatic int bin_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tilt_bin_quantizer.sv
// tilt_bin_quantizer: maps one signed axis sample onto a letter bin.
//   v   : signed sample
//   hit : |v| reaches the lowest bin edge (negative side only if USE_NEG)
//   neg : the hit came from the negative side
//   bin : highest bin whose edge |v| reaches, saturating at NUM_LETTERS-1
module tilt_bin_quantizer
    import tilt_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int NUM_LETTERS = 13,
    parameter int THRES       = 500,
    parameter int STEP        = 50,
    parameter int USE_NEG     = 1
) (
    input  logic signed [DATA_W-1:0]             v,
    output logic                                 hit,
    output logic                                 neg,
    output logic [bin_width(NUM_LETTERS)-1:0]    bin
);

    localparam int EW    = DATA_W + 2;
    localparam int BIN_W = bin_width(NUM_LETTERS);

    logic signed [EW-1:0] w_v;
    logic signed [EW-1:0] w_edge;
    logic                 w_pos;
    logic                 w_neg;

    assign w_v = {{2{v[DATA_W-1]}}, v};

    // Negative side is compared against negated edges so the most negative
    // sample never needs an absolute value.
    always_comb begin
        w_pos  = (w_v >= EW'(THRES));
        w_neg  = (USE_NEG != 0) && (w_v <= -EW'(THRES));
        w_edge = '0;
        bin    = '0;
        for (int unsigned i = 0; i < unsigned'(NUM_LETTERS); i++) begin
            w_edge = EW'(THRES + int'(i) * STEP);
            if ((w_pos && (w_v >= w_edge)) || (w_neg && (w_v <= -w_edge)))
                bin = BIN_W'(i);
        end
        hit = w_pos || w_neg;
        neg = w_neg;
    end

endmodule

// File: rtl/tilt_letter_decoder.sv
// tilt_letter_decoder: turns X/Y/Z tilt samples into ASCII letter codes.
//   clk, reset_n        : clock, asynchronous active-low reset
//   sample_valid, x/y/z : new signed sample this cycle
//   ascii_out, axis_out : letter code and source axis (0=X,1=Y,2=Z)
//   letter_valid/ready  : output handshake
//   overflow            : sticky, a qualified letter was dropped
module tilt_letter_decoder
    import tilt_pkg::*;
#(
    parameter int DATA_W        = 12,
    parameter int NUM_LETTERS   = 13,
    parameter int BASE_CHAR     = 8'h41,
    parameter int THRES         = 500,
    parameter int STEP          = 50,
    parameter int RELEASE_THRES = 300,
    parameter int HOLD_SAMPLES  = 4,
    parameter int USE_NEG       = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W-1:0] z,
    output logic [7:0]               ascii_out,
    output logic [1:0]               axis_out,
    output logic                     letter_valid,
    input  logic                     letter_ready,
    output logic                     overflow
);

    localparam int EW    = DATA_W + 2;
    localparam int BIN_W = bin_width(NUM_LETTERS);
    localparam int CNT_W = cnt_width(HOLD_SAMPLES);

    if (THRES + (NUM_LETTERS - 1) * STEP >= (1 << (DATA_W - 1))) begin : g_chk_range
        $error("top bin edge does not fit in DATA_W");
    end
    if (BASE_CHAR + (1 + USE_NEG) * NUM_LETTERS - 1 > 255) begin : g_chk_char
        $error("letter codes exceed 8 bits");
    end
    if (RELEASE_THRES >= THRES) begin : g_chk_rel
        $error("RELEASE_THRES must be below THRES");
    end
    if (HOLD_SAMPLES < 1) begin : g_chk_hold
        $error("HOLD_SAMPLES must be at least 1");
    end

    logic signed [DATA_W-1:0] w_axis_v [3];
    logic [2:0]               w_hit;
    logic [2:0]               w_neg;
    logic [2:0]               w_below;
    logic [BIN_W-1:0]         w_bin [3];

    assign w_axis_v[0] = x;
    assign w_axis_v[1] = y;
    assign w_axis_v[2] = z;

    for (genvar g = 0; g < 3; g++) begin : g_axis
        logic signed [EW-1:0] w_ext;

        tilt_bin_quantizer #(
            .DATA_W      (DATA_W),
            .NUM_LETTERS (NUM_LETTERS),
            .THRES       (THRES),
            .STEP        (STEP),
            .USE_NEG     (USE_NEG)
        ) u_quant (
            .v   (w_axis_v[g]),
            .hit (w_hit[g]),
            .neg (w_neg[g]),
            .bin (w_bin[g])
        );

        assign w_ext      = {{2{w_axis_v[g][DATA_W-1]}}, w_axis_v[g]};
        assign w_below[g] = (w_ext > -EW'(RELEASE_THRES)) && (w_ext < EW'(RELEASE_THRES));
    end

    logic       w_cand;
    logic [7:0] w_cand_code;
    logic [1:0] w_cand_axis;

    // Scan Z..X so the lowest-numbered hitting axis wins.
    always_comb begin
        w_cand      = 1'b0;
        w_cand_code = '0;
        w_cand_axis = AXIS_X;
        for (int unsigned k = 0; k < 3; k++) begin
            if (w_hit[2-k]) begin
                w_cand      = 1'b1;
                w_cand_axis = 2'(2 - k);
                w_cand_code = 8'(BASE_CHAR) + 8'(w_bin[2-k])
                            + (w_neg[2-k] ? 8'(NUM_LETTERS) : 8'd0);
            end
        end
    end

    tilt_state_e      r_state, w_state_nx;
    logic [7:0]       r_code, w_code_nx;
    logic [1:0]       r_axis, w_axis_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             w_load;
    logic             w_drop;
    logic             w_pop;

    always_comb begin
        w_state_nx = r_state;
        w_code_nx  = r_code;
        w_axis_nx  = r_axis;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (sample_valid && w_cand) begin
                    w_code_nx  = w_cand_code;
                    w_axis_nx  = w_cand_axis;
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = (HOLD_SAMPLES == 1) ? EMIT : QUALIFY;
                end
            end
            QUALIFY: begin
                if (sample_valid) begin
                    if (w_cand && (w_cand_code == r_code) && (w_cand_axis == r_axis)) begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                        if (r_cnt + CNT_W'(1) == CNT_W'(HOLD_SAMPLES))
                            w_state_nx = EMIT;
                    end else if (w_cand) begin
                        w_code_nx = w_cand_code;
                        w_axis_nx = w_cand_axis;
                        w_cnt_nx  = CNT_W'(1);
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            EMIT: begin
                w_load     = !letter_valid || letter_ready;
                w_drop     = !w_load;
                w_state_nx = RELEASE;
            end
            RELEASE: begin
                if (sample_valid && (&w_below))
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_pop = letter_valid && letter_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_code       <= '0;
            r_axis       <= '0;
            r_cnt        <= '0;
            ascii_out    <= '0;
            axis_out     <= '0;
            letter_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_code  <= w_code_nx;
            r_axis  <= w_axis_nx;
            r_cnt   <= w_cnt_nx;
            // A load on a popping edge takes priority so the new letter stays valid.
            if (w_load) begin
                ascii_out    <= r_code;
                axis_out     <= r_axis;
                letter_valid <= 1'b1;
            end else if (w_pop) begin
                letter_valid <= 1'b0;
            end
            if (w_drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tilt_letter_decoder.sv
module tb_tilt_letter_decoder;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sample_valid = 1'b0;
    logic              letter_ready = 1'b1;
    logic signed [11:0] x = '0;
    logic signed [11:0] y = '0;
    logic signed [11:0] z = '0;
    logic [7:0]        ascii_out;
    logic [1:0]        axis_out;
    logic              letter_valid;
    logic              overflow;

    // second instance with the negative bank disabled
    logic              sv2 = 1'b0;
    logic              ready2 = 1'b1;
    logic signed [11:0] x2 = '0;
    logic [7:0]        ascii2;
    logic [1:0]        axis2;
    logic              lv2;
    logic              ovf2;

    int total = 0;
    int bad   = 0;
    int q[$];
    int n2 = 0;

    always #5 clk = ~clk;

    tilt_letter_decoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .x            (x),
        .y            (y),
        .z            (z),
        .ascii_out    (ascii_out),
        .axis_out     (axis_out),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .overflow     (overflow)
    );

    tilt_letter_decoder #(.USE_NEG(0)) dut_pos (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sv2),
        .x            (x2),
        .y            (y),
        .z            (z),
        .ascii_out    (ascii2),
        .axis_out     (axis2),
        .letter_valid (lv2),
        .letter_ready (ready2),
        .overflow     (ovf2)
    );

    // Record every letter that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        #2;
        if (letter_valid && letter_ready) q.push_back({22'd0, axis_out, ascii_out});
        if (lv2) n2++;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic put(input int xv, input int yv, input int zv);
        x = 12'(xv);
        y = 12'(yv);
        z = 12'(zv);
        sample_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_letter(input string tag, input int exp_ascii, input int exp_axis);
        int e;
        check_eq({tag, "_count"}, q.size(), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check_eq({tag, "_ascii"}, e & 8'hff, exp_ascii);
            check_eq({tag, "_axis"}, (e >> 8) & 3, exp_axis);
        end
        q.delete();
    endtask

    task automatic expect_none(input string tag);
        check_eq({tag, "_count"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_valid", int'(letter_valid), 0);
        check_eq("rst_ascii", int'(ascii_out), 0);
        check_eq("rst_axis", int'(axis_out), 0);
        check_eq("rst_ovf", int'(overflow), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic letter, no repeat while held, re-arm after release
        repeat (4) put(620, 0, 0);
        repeat (4) put(620, 0, 0);
        gap(4);
        expect_letter("c1", 8'h43, 0);
        put(200, 0, 0);
        repeat (4) put(620, 0, 0);
        gap(4);
        expect_letter("c2", 8'h43, 0);
        put(0, 0, 0);

        // negative bank, lowest bin and saturated
        repeat (4) put(-500, 0, 0);
        gap(3);
        expect_letter("neg500", 8'h4E, 0);
        put(0, 0, 0);
        repeat (4) put(-2048, 0, 0);
        gap(3);
        expect_letter("neg2048", 8'h5A, 0);
        put(0, 0, 0);

        // same negative stimulus with the negative bank disabled
        x2 = -12'sd500;
        sv2 = 1'b1;
        repeat (4) @(negedge clk);
        x2 = '0;
        @(negedge clk);
        x2 = -12'sd2048;
        repeat (4) @(negedge clk);
        sv2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("noneg_letters", n2, 0);

        // axis priority, Y saturation, Z axis, below threshold
        repeat (4) put(550, 900, 0);
        gap(3);
        expect_letter("prio", 8'h42, 0);
        put(0, 0, 0);
        repeat (4) put(0, 1200, 0);
        gap(3);
        expect_letter("ysat", 8'h4D, 1);
        put(0, 0, 0);
        repeat (4) put(0, 0, 700);
        gap(3);
        expect_letter("zaxis", 8'h45, 2);
        put(0, 0, 0);
        repeat (6) put(499, 0, 0);
        gap(3);
        expect_none("x499");

        // bin change restarts dwell; gaps do not count; latency
        put(520, 0, 0); gap(1);
        put(520, 0, 0); gap(1);
        put(580, 0, 0); gap(1);
        put(580, 0, 0); gap(1);
        put(580, 0, 0); gap(1);
        put(580, 0, 0);
        check_eq("lat_edge1", int'(letter_valid), 0);
        gap(1);
        check_eq("lat_edge2", int'(letter_valid), 1);
        check_eq("lat_ascii", int'(ascii_out), 8'h42);
        gap(3);
        expect_letter("dwell", 8'h42, 0);
        put(0, 0, 0);

        // backpressure: second letter is dropped
        letter_ready = 1'b0;
        repeat (4) put(620, 0, 0);
        gap(3);
        check_eq("bp_valid", int'(letter_valid), 1);
        put(0, 0, 0);
        repeat (4) put(650, 0, 0);
        gap(3);
        check_eq("bp_ovf", int'(overflow), 1);
        check_eq("bp_hold_ascii", int'(ascii_out), 8'h43);
        check_eq("bp_hold_valid", int'(letter_valid), 1);
        letter_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_pop", int'(letter_valid), 0);
        check_eq("ovf_sticky", int'(overflow), 1);
        expect_letter("bp", 8'h43, 0);

        // asynchronous reset in the middle of qualification
        letter_ready = 1'b0;
        put(0, 0, 0);
        repeat (4) put(620, 0, 0);
        gap(3);
        check_eq("pre_rst_valid", int'(letter_valid), 1);
        put(0, 0, 0);
        repeat (3) put(620, 0, 0);
        sample_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", int'(letter_valid), 0);
        check_eq("arst_ascii", int'(ascii_out), 0);
        check_eq("arst_ovf", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        letter_ready = 1'b1;
        @(negedge clk);
        repeat (3) put(620, 0, 0);
        gap(4);
        expect_none("rst_three");
        put(620, 0, 0);
        gap(4);
        expect_letter("rst_four", 8'h43, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
